// File: rtl/reqack_pkg.sv
// Shared types and constants for the req/ack/done handshake initiator.
//   state_t     : initiator FSM states
//   err_t       : sticky error cause reported on err_code
//   DEFAULT_MAX : default latency bound, same value the responder checker uses
package reqack_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DONE,
      GAP,
      ERR
   } state_t;

   typedef enum logic [1:0] {
      E_NONE,
      E_ACK_TO,
      E_DONE_TO
   } err_t;

   localparam int unsigned DEFAULT_MAX = 5;

endpackage

// File: rtl/reqack_timer.sv
// Phase timer shared by the REQ and WAIT_DONE phases.
// Down-counter: clear loads limit-1, each enabled edge decrements, and the
// counter holds at zero. expired is the terminal-count compare, so it is
// high on the limit-th enabled edge after a clear.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   clear        : reload from limit on the next edge
//   enable       : phase active, count this edge
//   limit        : phase bound in edges (1..15)
//   expired      : bound reached on this edge
module reqack_timer (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       enable,
   input  logic [3:0] limit,
   output logic       expired
);

   logic [3:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= 4'd0;
      end else if (clear) begin
         count <= limit - 4'd1;
      end else if (enable && (count != 4'd0)) begin
         count <= count - 4'd1;
      end
   end

   assign expired = enable && (count == 4'd0);

endmodule

// File: rtl/reqack_initiator.sv
// Requesting side of the req/ack/done handshake.
// A start pulse in IDLE opens one transaction: req is raised until ack, then
// done is awaited. Either phase exceeding its bound ends in ERR with a
// one-cycle intrpt pulse and a sticky err_code.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start, ack/done ignored
// REQ       | req high, waiting up to MAX_ACK edges for ack
// WAIT_DONE | req low, waiting up to MAX_DONE edges for done
// GAP       | one cycle after completion, keeps req low between txns
// ERR       | one cycle with intrpt high after a timeout
//
// Ports:
//   clk, reset_n : clock, async active-low reset
//   start        : 1-cycle request to open a transaction
//   ack, done    : responder acknowledge / completion
//   req          : request to responder
//   busy         : transaction in progress
//   intrpt       : 1-cycle timeout pulse
//   err_code     : sticky last error cause (err_t)
//   txn_count    : completed transactions, wraps
module reqack_initiator
   import reqack_pkg::*;
#(
   parameter int unsigned MAX_ACK  = DEFAULT_MAX,
   parameter int unsigned MAX_DONE = DEFAULT_MAX,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             ack,
   input  logic             done,
   output logic             req,
   output logic             busy,
   output logic             intrpt,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] txn_count
);

   if ((MAX_ACK < 1) || (MAX_ACK > 15)) begin : g_bad_max_ack
      $error("reqack_initiator: MAX_ACK must be in 1..15");
   end
   if ((MAX_DONE < 1) || (MAX_DONE > 15)) begin : g_bad_max_done
      $error("reqack_initiator: MAX_DONE must be in 1..15");
   end

   localparam logic [3:0] ACK_LIM  = 4'(MAX_ACK);
   localparam logic [3:0] DONE_LIM = 4'(MAX_DONE);

   state_t     state;
   logic       tmr_clear;
   logic       tmr_enable;
   logic [3:0] tmr_limit;
   logic       tmr_expired;

   // The timer is reloaded whenever it is not timing a phase, and again on
   // the REQ->WAIT_DONE hand-over. The limit mux therefore selects the bound
   // of the phase being entered: MAX_DONE while leaving REQ, MAX_ACK otherwise.
   assign tmr_enable = (state == REQ) || (state == WAIT_DONE);
   assign tmr_clear  = !tmr_enable || ((state == REQ) && ack);
   assign tmr_limit  = (state == REQ) ? DONE_LIM : ACK_LIM;

   reqack_timer u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .limit   (tmr_limit),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         req       <= 1'b0;
         busy      <= 1'b0;
         intrpt    <= 1'b0;
         err_code  <= E_NONE;
         txn_count <= '0;
      end else begin
         intrpt <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= REQ;
                  req      <= 1'b1;
                  busy     <= 1'b1;
                  err_code <= E_NONE;
               end
            end
            REQ: begin
               if (ack) begin
                  req <= 1'b0;
                  if (done) begin
                     state     <= GAP;
                     txn_count <= txn_count + CNT_W'(1);
                  end else begin
                     state <= WAIT_DONE;
                  end
               end else if (tmr_expired) begin
                  state    <= ERR;
                  req      <= 1'b0;
                  intrpt   <= 1'b1;
                  err_code <= E_ACK_TO;
               end
            end
            WAIT_DONE: begin
               if (done) begin
                  state     <= GAP;
                  txn_count <= txn_count + CNT_W'(1);
               end else if (tmr_expired) begin
                  state    <= ERR;
                  intrpt   <= 1'b1;
                  err_code <= E_DONE_TO;
               end
            end
            GAP, ERR: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               req   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
